// File: rtl/ldst_pkg.sv
// Shared definitions for the load/store control sequencer: state and opcode-class
// encodings, control-word bit positions, default parameters and the ctrl decode.
package ldst_pkg;

    localparam int CTRL_W       = 18;
    localparam int CTRL_PCOUT   = 0;
    localparam int CTRL_MARIN   = 1;
    localparam int CTRL_INCPC   = 2;
    localparam int CTRL_ZIN     = 3;
    localparam int CTRL_ZLOWOUT = 4;
    localparam int CTRL_PCIN    = 5;
    localparam int CTRL_READ    = 6;
    localparam int CTRL_WRITE   = 7;
    localparam int CTRL_MDRIN   = 8;
    localparam int CTRL_MDROUT  = 9;
    localparam int CTRL_IRIN    = 10;
    localparam int CTRL_GRA     = 11;
    localparam int CTRL_GRB     = 12;
    localparam int CTRL_RIN     = 13;
    localparam int CTRL_ROUT    = 14;
    localparam int CTRL_BAOUT   = 15;
    localparam int CTRL_YIN     = 16;
    localparam int CTRL_COUT    = 17;

    localparam int         DEF_OPC_W    = 5;
    localparam int         DEF_WAIT_MAX = 8;
    localparam logic [4:0] DEF_ALU_ADD  = 5'b00011;
    localparam int         DEF_OPC_LD   = 0;
    localparam int         DEF_OPC_LDI  = 1;
    localparam int         DEF_OPC_ST   = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_FAULT = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_LD   = 2'd1,
        CLS_LDI  = 2'd2,
        CLS_ST   = 2'd3
    } cls_t;

    // Control word for a state; T5..T7 depend on the opcode class latched in T3.
    function automatic logic [CTRL_W-1:0] ctrl_for(input state_t s, input cls_t c);
        logic [CTRL_W-1:0] v;
        v = {CTRL_W{1'b0}};
        case (s)
            ST_T0: begin
                v[CTRL_PCOUT] = 1'b1; v[CTRL_MARIN] = 1'b1;
                v[CTRL_INCPC] = 1'b1; v[CTRL_ZIN]   = 1'b1;
            end
            ST_T1: begin
                v[CTRL_ZLOWOUT] = 1'b1; v[CTRL_PCIN]  = 1'b1;
                v[CTRL_READ]    = 1'b1; v[CTRL_MDRIN] = 1'b1;
            end
            ST_T2: begin
                v[CTRL_MDROUT] = 1'b1; v[CTRL_IRIN] = 1'b1;
            end
            ST_T3: begin
                v[CTRL_GRB] = 1'b1; v[CTRL_BAOUT] = 1'b1; v[CTRL_YIN] = 1'b1;
            end
            ST_T4: begin
                v[CTRL_COUT] = 1'b1; v[CTRL_ZIN] = 1'b1;
            end
            ST_T5: begin
                v[CTRL_ZLOWOUT] = 1'b1;
                if (c == CLS_LDI) begin
                    v[CTRL_GRA] = 1'b1; v[CTRL_RIN] = 1'b1;
                end else begin
                    v[CTRL_MARIN] = 1'b1;
                end
            end
            ST_T6: begin
                v[CTRL_MDRIN] = 1'b1;
                if (c == CLS_LD) begin
                    v[CTRL_READ] = 1'b1;
                end else begin
                    v[CTRL_GRA] = 1'b1; v[CTRL_ROUT] = 1'b1;
                end
            end
            ST_T7: begin
                if (c == CLS_LD) begin
                    v[CTRL_MDROUT] = 1'b1; v[CTRL_GRA] = 1'b1; v[CTRL_RIN] = 1'b1;
                end else begin
                    v[CTRL_WRITE] = 1'b1;
                end
            end
            default: v = {CTRL_W{1'b0}};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ldst_sequencer_if.sv
// Bundle between the sequencer and its datapath/memory side: run/handshake/opcode
// inputs and the registered control outputs.
interface ldst_sequencer_if
    import ldst_pkg::*;
#(
    parameter int OPC_W = DEF_OPC_W
);
    logic              run;
    logic              mem_ready;
    logic [OPC_W-1:0]  ir_opcode;
    logic [CTRL_W-1:0] ctrl;
    logic [OPC_W-1:0]  alu_op;
    logic              busy;
    logic              illegal_op;
    logic              timeout_err;

    modport master (
        output run, mem_ready, ir_opcode,
        input  ctrl, alu_op, busy, illegal_op, timeout_err
    );

    modport slave (
        input  run, mem_ready, ir_opcode,
        output ctrl, alu_op, busy, illegal_op, timeout_err
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready in a memory state and flags when the
// wait limit is reached without a handshake.
module mem_wait_timer #(
    parameter int WAIT_MAX = 8
) (
    input  logic Clock,
    input  logic clear,
    input  logic start,
    input  logic ready,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

    logic [7:0] r_wait_cnt;

    // Held at zero outside a memory state, so every entry starts counting from zero.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_wait_cnt <= 8'd0;
        end else if (!start) begin
            r_wait_cnt <= 8'd0;
        end else if (!ready && (r_wait_cnt != LIMIT)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // A handshake in the cycle the limit is reached still counts as success.
    assign expired = start && !ready && (r_wait_cnt == LIMIT);

endmodule

// File: rtl/ldst_sequencer.sv
// Hard-wired control sequencer for LD / LDI / ST: fetch (T0..T2), decode (T3),
// effective-address add (T4) and execute (T5..T7) with memory-wait timeout.
module ldst_sequencer
    import ldst_pkg::*;
#(
    parameter int               OPC_W    = DEF_OPC_W,
    parameter int               WAIT_MAX = DEF_WAIT_MAX,
    parameter logic [OPC_W-1:0] ALU_ADD  = OPC_W'(DEF_ALU_ADD),
    parameter logic [OPC_W-1:0] OPC_LD   = OPC_W'(DEF_OPC_LD),
    parameter logic [OPC_W-1:0] OPC_LDI  = OPC_W'(DEF_OPC_LDI),
    parameter logic [OPC_W-1:0] OPC_ST   = OPC_W'(DEF_OPC_ST)
) (
    input  logic           Clock,
    input  logic           clear,
    ldst_sequencer_if.slave bus
);
    state_t            r_state;
    cls_t              r_cls;
    logic [CTRL_W-1:0] r_ctrl;
    logic [OPC_W-1:0]  r_alu_op;
    logic              r_busy;
    logic              r_illegal;
    logic              r_timeout;

    state_t w_next_state;
    cls_t   w_next_cls;
    logic   w_illegal;
    logic   w_in_mem;
    logic   w_expired;

    assign w_in_mem = (r_state == ST_T1)
                   || ((r_state == ST_T6) && (r_cls == CLS_LD))
                   || ((r_state == ST_T7) && (r_cls == CLS_ST));

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .Clock   (Clock),
        .clear   (clear),
        .start   (w_in_mem),
        .ready   (bus.mem_ready),
        .expired (w_expired)
    );

    // Next-state and opcode-class selection; the class only changes in T3.
    always_comb begin
        w_next_state = r_state;
        w_next_cls   = r_cls;
        w_illegal    = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.run) w_next_state = ST_T0; else w_next_state = ST_IDLE;
            ST_T0:   w_next_state = ST_T1;
            ST_T1: begin
                if (bus.mem_ready)  w_next_state = ST_T2;
                else if (w_expired) w_next_state = ST_FAULT;
                else                w_next_state = ST_T1;
            end
            ST_T2:   w_next_state = ST_T3;
            ST_T3: begin
                if (bus.ir_opcode == OPC_LD) begin
                    w_next_cls = CLS_LD;  w_next_state = ST_T4;
                end else if (bus.ir_opcode == OPC_LDI) begin
                    w_next_cls = CLS_LDI; w_next_state = ST_T4;
                end else if (bus.ir_opcode == OPC_ST) begin
                    w_next_cls = CLS_ST;  w_next_state = ST_T4;
                end else begin
                    w_next_cls = CLS_NONE; w_illegal = 1'b1; w_next_state = ST_IDLE;
                end
            end
            ST_T4:   w_next_state = ST_T5;
            ST_T5: if (r_cls == CLS_LDI) w_next_state = ST_IDLE; else w_next_state = ST_T6;
            ST_T6: begin
                if (r_cls != CLS_LD)     w_next_state = ST_T7;
                else if (bus.mem_ready)  w_next_state = ST_T7;
                else if (w_expired)      w_next_state = ST_FAULT;
                else                     w_next_state = ST_T6;
            end
            ST_T7: begin
                if (r_cls != CLS_ST)     w_next_state = ST_IDLE;
                else if (bus.mem_ready)  w_next_state = ST_IDLE;
                else if (w_expired)      w_next_state = ST_FAULT;
                else                     w_next_state = ST_T7;
            end
            ST_FAULT: w_next_state = ST_FAULT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_cls     <= CLS_NONE;
            r_ctrl    <= {CTRL_W{1'b0}};
            r_alu_op  <= {OPC_W{1'b0}};
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cls     <= w_next_cls;
            r_ctrl    <= ctrl_for(w_next_state, w_next_cls);
            r_alu_op  <= (w_next_state == ST_T4) ? ALU_ADD : {OPC_W{1'b0}};
            r_busy    <= (w_next_state != ST_IDLE) && (w_next_state != ST_FAULT);
            r_illegal <= w_illegal;
            r_timeout <= r_timeout | w_expired;
        end
    end

    assign bus.ctrl        = r_ctrl;
    assign bus.alu_op      = r_alu_op;
    assign bus.busy        = r_busy;
    assign bus.illegal_op  = r_illegal;
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Randomised scoreboard bench for ldst_sequencer: instructions are generated from
// the step rules, expected output words are queued, and a monitor pops on activity.
module tb_ldst_sequencer;
    import ldst_pkg::*;

    localparam int         WM  = 8;
    localparam logic [4:0] ADD = 5'b00011;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        alu;
        logic              busy;
        logic              ill;
        logic              tmo;
    } rec_t;

    logic Clock = 1'b0;
    logic clear;

    ldst_sequencer_if #(.OPC_W(5)) bus_if ();

    ldst_sequencer #(
        .OPC_W(5), .WAIT_MAX(WM), .ALU_ADD(ADD),
        .OPC_LD(5'd0), .OPC_LDI(5'd1), .OPC_ST(5'd2)
    ) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus_if)
    );

    always #5 Clock = ~Clock;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    rec_t mon_a;
    rec_t mon_e;

    function automatic logic [CTRL_W-1:0] b(input int i);
        logic [CTRL_W-1:0] one;
        one = {{(CTRL_W-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    function automatic rec_t mk(input logic [CTRL_W-1:0] c, input logic [4:0] a,
                                input logic bz, input logic il, input logic tm);
        rec_t r;
        r.ctrl = c; r.alu = a; r.busy = bz; r.ill = il; r.tmo = tm;
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] ro();
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic int rdel();
        int p;
        p = int'($urandom_range(0, 99));
        if (p < 8)       return WM + 1;
        else if (p < 16) return WM;
        else             return int'($urandom_range(0, 3));
    endfunction

    rec_t R_T0, R_T1, R_T2, R_T3, R_T4, R_T5M, R_T5I, R_T6L, R_T6S, R_T7L, R_T7S, R_ILL, R_FLT;

    initial begin
        R_T0  = mk(b(CTRL_PCOUT) | b(CTRL_MARIN) | b(CTRL_INCPC) | b(CTRL_ZIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T1  = mk(b(CTRL_ZLOWOUT) | b(CTRL_PCIN) | b(CTRL_READ) | b(CTRL_MDRIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T2  = mk(b(CTRL_MDROUT) | b(CTRL_IRIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T3  = mk(b(CTRL_GRB) | b(CTRL_BAOUT) | b(CTRL_YIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T4  = mk(b(CTRL_COUT) | b(CTRL_ZIN), ADD, 1'b1, 1'b0, 1'b0);
        R_T5M = mk(b(CTRL_ZLOWOUT) | b(CTRL_MARIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T5I = mk(b(CTRL_ZLOWOUT) | b(CTRL_GRA) | b(CTRL_RIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T6L = mk(b(CTRL_READ) | b(CTRL_MDRIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T6S = mk(b(CTRL_GRA) | b(CTRL_ROUT) | b(CTRL_MDRIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T7L = mk(b(CTRL_MDROUT) | b(CTRL_GRA) | b(CTRL_RIN), 5'd0, 1'b1, 1'b0, 1'b0);
        R_T7S = mk(b(CTRL_WRITE), 5'd0, 1'b1, 1'b0, 1'b0);
        R_ILL = mk({CTRL_W{1'b0}}, 5'd0, 1'b0, 1'b1, 1'b0);
        R_FLT = mk({CTRL_W{1'b0}}, 5'd0, 1'b0, 1'b0, 1'b1);
    end

    // One clock of stimulus; e is what the outputs must show after this edge.
    task automatic step(input logic run, input logic rdy, input logic [4:0] opc,
                        input logic clr, input rec_t e);
        bus_if.run       = run;
        bus_if.mem_ready = rdy;
        bus_if.ir_opcode = opc;
        clear            = clr;
        if (e != '0) exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus_if.ctrl, bus_if.alu_op, bus_if.busy, bus_if.illegal_op, bus_if.timeout_err} != '0) begin
            failures++;
            $display("FAIL %s got ctrl=%h alu=%h busy=%b ill=%b tmo=%b, want all zero", name,
                     bus_if.ctrl, bus_if.alu_op, bus_if.busy, bus_if.illegal_op, bus_if.timeout_err);
        end
    endtask

    // Memory wait: handshake after d low cycles; oc 0=done, 1=fault, 2=cleared.
    task automatic mem_wait(input int d, input rec_t hold, input rec_t done,
                            input int clr_at, output int oc);
        oc = 1;
        for (int j = 0; j <= WM; j++) begin
            if (j == clr_at) begin
                step(rb(), rb(), ro(), 1'b1, '0); oc = 2; return;
            end
            if (j == d) begin
                step(rb(), 1'b1, ro(), 1'b0, done); oc = 0; return;
            end
            if (j == WM) begin
                step(rb(), 1'b0, ro(), 1'b0, R_FLT); oc = 1; return;
            end
            step(rb(), 1'b0, ro(), 1'b0, hold);
        end
    endtask

    task automatic fault_recover();
        int n;
        n = int'($urandom_range(1, 3));
        for (int k = 0; k < n; k++) step(rb(), rb(), ro(), 1'b0, R_FLT);
        step(rb(), rb(), ro(), 1'b1, '0);
        check_zero("after_fault_clear");
    endtask

    task automatic instr(input logic [4:0] opc, input int d1, input int d2, input int clr2);
        int oc;
        step(1'b1, rb(), ro(), 1'b0, R_T0);
        step(rb(), rb(), ro(), 1'b0, R_T1);
        mem_wait(d1, R_T1, R_T2, -1, oc);
        if (oc == 1) begin fault_recover(); return; end
        step(rb(), rb(), ro(), 1'b0, R_T3);
        if (opc > 5'd2) begin
            step(rb(), rb(), opc, 1'b0, R_ILL);
            return;
        end
        step(rb(), rb(), opc, 1'b0, R_T4);
        step(rb(), rb(), ro(), 1'b0, (opc == 5'd1) ? R_T5I : R_T5M);
        if (opc == 5'd1) begin
            step(rb(), rb(), ro(), 1'b0, '0);
            return;
        end
        if (opc == 5'd0) begin
            step(rb(), rb(), ro(), 1'b0, R_T6L);
            mem_wait(d2, R_T6L, R_T7L, clr2, oc);
            if (oc == 0) step(rb(), rb(), ro(), 1'b0, '0);
        end else begin
            step(rb(), rb(), ro(), 1'b0, R_T6S);
            step(rb(), rb(), ro(), 1'b0, R_T7S);
            mem_wait(d2, R_T7S, '0, clr2, oc);
        end
        if (oc == 1) fault_recover();
        else if (oc == 2) check_zero("after_midwait_clear");
    endtask

    // Monitor: any non-quiet output word must match the next queued expectation.
    initial begin
        forever begin
            @(negedge Clock);
            mon_a = mk(bus_if.ctrl, bus_if.alu_op, bus_if.busy, bus_if.illegal_op, bus_if.timeout_err);
            if (mon_a != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h want=none", mon_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_a !== mon_e) begin
                        failures++;
                        $display("FAIL output_word got=%h want=%h", mon_a, mon_e);
                    end
                end
                checks++;
                if ((mon_a.ctrl[CTRL_READ] && mon_a.ctrl[CTRL_WRITE]) ||
                    (mon_a.ctrl[CTRL_MDROUT] && mon_a.ctrl[CTRL_ZLOWOUT])) begin
                    failures++;
                    $display("FAIL exclusive_ctrl got=%h want no read+write or mdrout+zlowout", mon_a.ctrl);
                end
            end
        end
    end

    initial begin
        bus_if.run = 1'b0; bus_if.mem_ready = 1'b0; bus_if.ir_opcode = 5'd0; clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check_zero("reset_state");
        step(1'b0, 1'b1, 5'd0, 1'b0, '0);

        instr(5'd0, 1, 1, -1);          // LD, one wait per read
        instr(5'd1, 0, 0, -1);          // LDI
        instr(5'd2, 0, 3, -1);          // ST, write stretched 3 cycles
        instr(5'd31, 0, 0, -1);         // undecoded opcode
        instr(5'd0, WM + 1, 0, -1);     // fetch timeout
        instr(5'd0, WM, WM, -1);        // handshake exactly at the limit
        instr(5'd0, 0, 5, 2);           // clear during LD-T6 wait
        instr(5'd0, 1, 1, -1);
        instr(5'd2, 1, WM + 1, -1);     // store timeout

        for (int i = 0; i < 150; i++) begin
            logic [4:0] opc;
            int         clr2;
            int         gap;
            opc  = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 2)) : ro();
            clr2 = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            instr(opc, rdel(), rdel(), clr2);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(1'b0, rb(), ro(), 1'b0, '0);
        end

        repeat (3) step(1'b0, rb(), ro(), 1'b0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldst_sequencer.md
LDST_SEQUENCER -- requirements
Module: ldst_sequencer

Interface
REQ-001 Parameter OPC_W, default 5, width of the opcode field and the ALU op code.
REQ-002 Parameter WAIT_MAX, default 8, maximum cycles a memory state may wait for mem_ready; legal range 1..255.
REQ-003 Parameter ALU_ADD, default 5'b00011, ALU op code issued for effective-address add.
REQ-004 Parameters OPC_LD, OPC_LDI and OPC_ST, defaults 0, 1 and 2, decoded opcodes.
REQ-005 Clock  input  1  single system clock, all state updates on rising edge.
REQ-006 clear  input  1  reset; synchronous, active-high.
REQ-007 run  input  1  permits a new fetch when high.
REQ-008 mem_ready  input  1  memory handshake; high for one or more cycles when the Read or Write access completes.
REQ-009 ir_opcode  input  OPC_W  opcode field of the IR; sampled only in state T3.
REQ-010 ctrl  output  CTRL_W  one-hot-per-signal control word; bit indices are defined in the shared package.
REQ-011 Control bits in ctrl: PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout.
REQ-012 alu_op  output  OPC_W  ALU operation; ALU_ADD in T4, otherwise zero.
REQ-013 busy  output  1  high in every state except IDLE and FAULT.
REQ-014 illegal_op  output  1  one-cycle pulse on an undecoded opcode.
REQ-015 timeout_err  output  1  sticky flag; cleared only by clear.

Function
REQ-016 All outputs SHALL be registered Moore outputs, decoded from the present state and wait counter.
REQ-017 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, T7 and FAULT.
REQ-018 IDLE: all ctrl bits low; go to T0 when run=1, else hold.
REQ-019 T0: PCout, MARin, IncPC, Zin; go to T1.
REQ-020 T1: Zlowout, PCin, Read, MDRin; hold until mem_ready=1, then go to T2.
REQ-021 T2: MDRout, IRin; go to T3.
REQ-022 T3: Grb, BAout, Yin; decode ir_opcode: LD, LDI or ST go to T4; any other opcode pulses illegal_op and goes to IDLE.
REQ-023 T4: Cout, Zin, alu_op=ALU_ADD; go to T5.
REQ-024 T5 for LD or ST: Zlowout, MARin; go to T6.
REQ-025 T5 for LDI: Zlowout, Gra, Rin; go to IDLE.
REQ-026 T6 for LD: Read, MDRin; hold until mem_ready=1, then go to T7.
REQ-027 T6 for ST: Gra, Rout, MDRin; go to T7.
REQ-028 T7 for LD: MDRout, Gra, Rin; go to IDLE.
REQ-029 T7 for ST: Write; hold until mem_ready=1, then go to IDLE.
REQ-030 The decoded opcode class SHALL be latched in T3 and held through T7; ir_opcode changes after T3 SHALL have no effect.
REQ-031 Wait counter: zero on entry to a memory state (T1, LD-T6, ST-T7); increments each cycle mem_ready=0 in that state.
REQ-032 When the wait counter reaches WAIT_MAX with mem_ready still 0, the FSM SHALL go to FAULT and set timeout_err.
REQ-033 mem_ready=1 in the same cycle the counter reaches WAIT_MAX SHALL count as success; no fault is raised.
REQ-034 mem_ready outside a memory state SHALL be ignored.
REQ-035 FAULT: all ctrl bits low; hold until clear.
REQ-036 run=0 mid-instruction SHALL NOT abort the instruction; it takes effect only at IDLE.
REQ-037 Read and Write SHALL never be asserted in the same cycle; MDRout and Zlowout SHALL never be asserted in the same cycle.

Reset
REQ-038 clear=1 at a rising Clock edge SHALL force IDLE, ctrl=0, alu_op=0, busy=0, illegal_op=0, timeout_err=0 and wait counter=0, from any state including mid-wait.
REQ-039 The first fetch SHALL begin no earlier than the first cycle after clear deasserts with run=1.

Structure
REQ-040 Package ldst_pkg SHALL hold the state enumeration, the ctrl bit-index constants, CTRL_W, and the default opcode and ALU_ADD constants.
REQ-041 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer, with ports Clock, clear, start, ready and expired.

Verification
REQ-042 LD, opcode 0, mem_ready high 1 cycle after each Read: IDLE, T0..T7, IDLE in 11 cycles; Rin high only in T7.
REQ-043 LDI, opcode 1: T0..T5 then IDLE; no Read after T1; alu_op=5'b00011 only in T4.
REQ-044 ST, opcode 2, mem_ready delayed 3 cycles in T7: Write high for exactly 4 cycles; Read low throughout T5..T7.
REQ-045 Opcode 5'b11111: illegal_op pulses 1 cycle after T3; next state IDLE; no Rin or Write asserted.
REQ-046 WAIT_MAX=8, mem_ready held low in T1: FAULT after 8 wait cycles with timeout_err=1; clear then returns IDLE with timeout_err=0.
REQ-047 clear asserted in LD-T6 mid-wait: next cycle IDLE with all outputs zero; next LD completes normally.
